exec_alu_forward: RTL and testbench
===================================

// Module: exec_alu_forward
// PURPOSE
//  Execute-stage datapath: operand forwarding, a 16-bit ALU and the 3-bit condition-code register (CCR).
//  - Sits between the decode/execute and execute/memory pipeline registers.
//  - Forwarding takes operands from the MEM-stage ALU result or the WB-stage data.
//  - The registered CCR feeds the branch decision (flag_any) back to fetch.
// PARAMETERS
//  W        16  datapath width (ALU, operands, ports)
//  SHW      5   shift-amount width
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous, active-low; clears CCR
//  rs_data        in   W   source register value from decode/exec reg
//  rd_data        in   W   destination register value from decode/exec reg
//  imm_value      in   W   immediate operand
//  use_imm        in   1   1: src operand = imm_value (no src forwarding)
//  shmnt          in   SHW shift amount
//  in_port        in   W   external input port value
//  alu_op         in   4   operation code (table below)
//  alu_en         in   1   0 = bubble: CCR not updated
//  rs_addr        in   3   source register index (execute stage)
//  rd_addr        in   3   destination register index (execute stage)
//  rd_mem         in   3   destination index in MEM stage
//  rd_wb          in   3   destination index in WB stage
//  regwrite_mem   in   1   MEM-stage instruction writes a register
//  regwrite_wb    in   1   WB-stage instruction writes a register
//  alu_result_mem in   W   MEM-stage ALU result
//  wb_data        in   W   WB-stage write-back data
//  sel_src        out  2   src forwarding select: 00 own, 01 MEM, 10 WB
//  sel_dst        out  2   dst forwarding select, same encoding
//  src            out  W   forwarded src operand
//  dst            out  W   forwarded dst operand (also Out_Port / jump target)
//  alu_result     out  W   combinational ALU result
//  ccr            out  3   registered flags: [0]=Z, [1]=N, [2]=C
//  flag_any       out  1   ccr[0] | ccr[1] | ccr[2]
// BEHAVIOUR
//  Forwarding (combinational):
//  - sel_dst = 01 if regwrite_mem && rd_mem==rd_addr; else 10 if regwrite_wb && rd_wb==rd_addr; else 00.
//  - sel_src: same rule against rs_addr; forced to 00 when use_imm=1.
//  - MEM stage has priority over WB when both match.
//  - Base operands: src base = use_imm ? imm_value : rs_data; dst base = rd_data.
//  ALU ops (A=dst, B=src), all combinational, results truncated to W bits:
//  - 0 NOP -> A;  1 SETC -> A, C=1;  2 CLRC -> A, C=0
//  - 3 NOT ~A;  4 INC A+1;  5 DEC A-1;  6 MOV B;  7 ADD A+B;  8 SUB A-B
//  - 9 AND A&B;  10 OR A|B;  11 SHL A<<shmnt;  12 SHR A>>shmnt (logical)
//  - 13 IN in_port;  14,15 reserved -> behave as NOP
//  Flags:
//  - Z/N updated from the result by ops 3-5 and 7-12; unchanged by 0,6,13-15.
//  - C: INC/ADD = carry out of bit W-1; DEC/SUB = borrow (1 when A<B unsigned; DEC: A==0).
//  - C, SHL with shmnt in 1..16: A[16-shmnt]; SHR: A[shmnt-1].
//  - C, shifts: shmnt=0 -> result A, C unchanged; shmnt>16 -> result 0, C=0.
//  - C unchanged by NOT, AND, OR, MOV, IN.
//  - SETC/CLRC change only C.
//  CCR register:
//  - Loads the next-flag value on the rising clk edge when alu_en=1; holds when alu_en=0.
//  - reset low clears ccr to 3'b000 immediately (asynchronous), regardless of clk.
//  - flag_any follows the registered ccr.
// TESTING
//  - Reset: drive reset=0 mid-cycle -> ccr=000, flag_any=0 without a clock edge.
//  - ADD: A=16'hFFFF, B=16'h0001, op=7 -> result 0000; after edge ccr Z=1, N=0, C=1.
//  - SUB: A=3, B=5, op=8 -> result FFFE; ccr Z=0, N=1, C=1. Repeat with alu_en=0 -> ccr unchanged.
//  - Forwarding: rd_addr=2, rd_mem=2, rd_wb=2, both regwrite=1 -> sel_dst=01, dst=alu_result_mem.
//    With regwrite_mem=0 -> sel_dst=10, dst=wb_data.
//  - Immediate: use_imm=1 with a matching rs_addr -> sel_src=00, src=imm_value.
//  - Shifts: A=16'h8001, SHL shmnt=1 -> 0002, C=1; SHR shmnt=1 -> 4000, C=1; shmnt=0 -> 8001, C held.

Source files
------------

// File: rtl/exec_alu_forward_if.sv
// Execute-stage operand/result bundle between the decode-exec register, the
// forwarding sources (MEM/WB) and the exec-mem register.
// Latency: wires only. Backpressure: none, it is a plain pipeline datapath.
//
// Ports (slave = execute stage):
//   in : rs_data, rd_data, imm_value, use_imm, shmnt, in_port, alu_op, alu_en,
//        rs_addr, rd_addr, rd_mem, rd_wb, regwrite_mem, regwrite_wb,
//        alu_result_mem, wb_data
//   out: sel_src, sel_dst, src, dst, alu_result, ccr, flag_any
interface exec_alu_forward_if #(
    parameter int W   = 16,
    parameter int SHW = 5
);
    // Operands from the decode/execute register
    logic [W-1:0]   rs_data;
    logic [W-1:0]   rd_data;
    logic [W-1:0]   imm_value;
    logic           use_imm;
    logic [SHW-1:0] shmnt;
    logic [W-1:0]   in_port;
    logic [3:0]     alu_op;
    logic           alu_en;

    // Register indices and downstream writers for hazard detection
    logic [2:0]     rs_addr;
    logic [2:0]     rd_addr;
    logic [2:0]     rd_mem;
    logic [2:0]     rd_wb;
    logic           regwrite_mem;
    logic           regwrite_wb;
    logic [W-1:0]   alu_result_mem;
    logic [W-1:0]   wb_data;

    // Results
    logic [1:0]     sel_src;
    logic [1:0]     sel_dst;
    logic [W-1:0]   src;
    logic [W-1:0]   dst;
    logic [W-1:0]   alu_result;
    logic [2:0]     ccr;
    logic           flag_any;

    modport master (
        output rs_data, rd_data, imm_value, use_imm, shmnt, in_port,
               alu_op, alu_en, rs_addr, rd_addr, rd_mem, rd_wb,
               regwrite_mem, regwrite_wb, alu_result_mem, wb_data,
        input  sel_src, sel_dst, src, dst, alu_result, ccr, flag_any
    );

    modport slave (
        input  rs_data, rd_data, imm_value, use_imm, shmnt, in_port,
               alu_op, alu_en, rs_addr, rd_addr, rd_mem, rd_wb,
               regwrite_mem, regwrite_wb, alu_result_mem, wb_data,
        output sel_src, sel_dst, src, dst, alu_result, ccr, flag_any
    );
endinterface

// File: rtl/exec_alu_forward.sv
// Execute stage: operand forwarding from MEM/WB, 16-bit ALU, 3-bit CCR {C,N,Z}.
// Latency: forwarding and ALU result combinational; CCR updates on the next clk edge.
// Backpressure: none; alu_en=0 marks a bubble and freezes the CCR.
//
// Ports: clk, reset (async active-low, clears CCR), bus (exec_alu_forward_if.slave).
module exec_alu_forward #(
    parameter int W   = 16,
    parameter int SHW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    exec_alu_forward_if.slave    bus
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_SETC = 4'd1,
        OP_CLRC = 4'd2,
        OP_NOT  = 4'd3,
        OP_INC  = 4'd4,
        OP_DEC  = 4'd5,
        OP_MOV  = 4'd6,
        OP_ADD  = 4'd7,
        OP_SUB  = 4'd8,
        OP_AND  = 4'd9,
        OP_OR   = 4'd10,
        OP_SHL  = 4'd11,
        OP_SHR  = 4'd12,
        OP_IN   = 4'd13
    } alu_op_e;

    localparam logic [1:0] SEL_OWN = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // CCR bit positions
    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

    // ------------------------------------------------------------------
    // Forwarding select
    // ------------------------------------------------------------------
    logic [1:0]   sel_src;
    logic [1:0]   sel_dst;
    logic [W-1:0] src_base;
    logic [W-1:0] src_op;
    logic [W-1:0] dst_op;

    always_comb begin
        // MEM is the younger producer, so it wins over WB.
        sel_dst = SEL_OWN;
        if (bus.regwrite_mem && (bus.rd_mem == bus.rd_addr)) begin
            sel_dst = SEL_MEM;
        end else if (bus.regwrite_wb && (bus.rd_wb == bus.rd_addr)) begin
            sel_dst = SEL_WB;
        end

        // An immediate operand never comes from the register file, so a
        // stale rs_addr match must not override it.
        sel_src = SEL_OWN;
        if (!bus.use_imm) begin
            if (bus.regwrite_mem && (bus.rd_mem == bus.rs_addr)) begin
                sel_src = SEL_MEM;
            end else if (bus.regwrite_wb && (bus.rd_wb == bus.rs_addr)) begin
                sel_src = SEL_WB;
            end
        end
    end

    always_comb begin
        src_base = bus.use_imm ? bus.imm_value : bus.rs_data;

        case (sel_src)
            SEL_MEM: src_op = bus.alu_result_mem;
            SEL_WB:  src_op = bus.wb_data;
            default: src_op = src_base;
        endcase

        case (sel_dst)
            SEL_MEM: dst_op = bus.alu_result_mem;
            SEL_WB:  dst_op = bus.wb_data;
            default: dst_op = bus.rd_data;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU (A = dst operand, B = src operand)
    // ------------------------------------------------------------------
    logic [W:0]   add_w;
    logic [W:0]   sub_w;
    logic [W:0]   inc_w;
    logic [W:0]   dec_w;
    logic [W:0]   shl_w;
    logic [W:0]   shr_w;
    logic         sh_zero;
    logic         sh_over;

    always_comb begin
        // One extra bit holds carry-out (add) or borrow (subtract, set when A<B).
        add_w = {1'b0, dst_op} + {1'b0, src_op};
        sub_w = {1'b0, dst_op} - {1'b0, src_op};
        inc_w = {1'b0, dst_op} + (W+1)'(1);
        dec_w = {1'b0, dst_op} - (W+1)'(1);

        // The extra bit catches the last bit shifted out:
        // SHL -> shl_w[W] = A[W-shmnt], SHR -> shr_w[0] = A[shmnt-1].
        shl_w = {1'b0, dst_op} << bus.shmnt;
        shr_w = {dst_op, 1'b0} >> bus.shmnt;

        sh_zero = (bus.shmnt == '0);
        sh_over = (int'(bus.shmnt) > W);
    end

    logic [W-1:0] alu_res;
    logic         upd_zn;
    logic         upd_c;
    logic         c_new;

    always_comb begin
        alu_res = dst_op;
        upd_zn  = 1'b0;
        upd_c   = 1'b0;
        c_new   = 1'b0;

        case (alu_op_e'(bus.alu_op))
            OP_SETC: begin
                upd_c = 1'b1;
                c_new = 1'b1;
            end
            OP_CLRC: begin
                upd_c = 1'b1;
                c_new = 1'b0;
            end
            OP_NOT: begin
                alu_res = ~dst_op;
                upd_zn  = 1'b1;
            end
            OP_INC: begin
                alu_res = inc_w[W-1:0];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_new   = inc_w[W];
            end
            OP_DEC: begin
                alu_res = dec_w[W-1:0];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_new   = dec_w[W];
            end
            OP_MOV: begin
                alu_res = src_op;
            end
            OP_ADD: begin
                alu_res = add_w[W-1:0];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_new   = add_w[W];
            end
            OP_SUB: begin
                alu_res = sub_w[W-1:0];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_new   = sub_w[W];
            end
            OP_AND: begin
                alu_res = dst_op & src_op;
                upd_zn  = 1'b1;
            end
            OP_OR: begin
                alu_res = dst_op | src_op;
                upd_zn  = 1'b1;
            end
            OP_SHL: begin
                upd_zn = 1'b1;
                // Zero shift passes A through and leaves C alone.
                if (sh_over) begin
                    alu_res = '0;
                    upd_c   = 1'b1;
                    c_new   = 1'b0;
                end else if (!sh_zero) begin
                    alu_res = shl_w[W-1:0];
                    upd_c   = 1'b1;
                    c_new   = shl_w[W];
                end
            end
            OP_SHR: begin
                upd_zn = 1'b1;
                if (sh_over) begin
                    alu_res = '0;
                    upd_c   = 1'b1;
                    c_new   = 1'b0;
                end else if (!sh_zero) begin
                    alu_res = shr_w[W:1];
                    upd_c   = 1'b1;
                    c_new   = shr_w[0];
                end
            end
            OP_IN: begin
                alu_res = bus.in_port;
            end
            default: begin
                // NOP and the reserved codes 14/15 pass A, flags untouched.
                alu_res = dst_op;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Condition-code register
    // ------------------------------------------------------------------
    logic [2:0] ccr_d;
    logic [2:0] ccr_q;

    always_comb begin
        ccr_d = ccr_q;
        if (bus.alu_en) begin
            if (upd_zn) begin
                ccr_d[CCR_Z] = (alu_res == '0);
                ccr_d[CCR_N] = alu_res[W-1];
            end
            if (upd_c) begin
                ccr_d[CCR_C] = c_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ccr_q <= 3'b000;
        end else begin
            ccr_q <= ccr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.sel_src    = sel_src;
    assign bus.sel_dst    = sel_dst;
    assign bus.src        = src_op;
    assign bus.dst        = dst_op;
    assign bus.alu_result = alu_res;
    assign bus.ccr        = ccr_q;
    assign bus.flag_any   = |ccr_q;

endmodule

// File: tb/tb_exec_alu_forward.sv
// Bench for exec_alu_forward: directed vectors push hand-computed expectations
// into a queue; a monitor pops one per strobed cycle and compares.
// Combinational outputs are sampled on the falling edge, the CCR 1ns after the rising edge.
module tb_exec_alu_forward;

    logic clk;
    logic reset;

    exec_alu_forward_if #(.W(16), .SHW(5)) bus ();

    exec_alu_forward #(.W(16), .SHW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [15:0] src;
        logic [15:0] dst;
        logic [1:0]  ssel;
        logic [1:0]  dsel;
        logic [2:0]  ccr_now;
        logic [2:0]  ccr_after;
        bit          do_comb;
        bit          do_now;
        bit          do_after;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_vld;
    int    n_total;
    int    n_pass;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                check("monitor_queue_nonempty", 32'd0, 32'd1);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.do_comb) begin
                    check({nm, ".result"},  32'(bus.alu_result), 32'(e.res));
                    check({nm, ".src"},     32'(bus.src),        32'(e.src));
                    check({nm, ".dst"},     32'(bus.dst),        32'(e.dst));
                    check({nm, ".sel_src"}, 32'(bus.sel_src),    32'(e.ssel));
                    check({nm, ".sel_dst"}, 32'(bus.sel_dst),    32'(e.dsel));
                end
                if (e.do_now) begin
                    check({nm, ".ccr_now"},  32'(bus.ccr),      32'(e.ccr_now));
                    check({nm, ".any_now"},  32'(bus.flag_any), 32'(|e.ccr_now));
                end
                if (e.do_after) begin
                    @(posedge clk);
                    #1;
                    check({nm, ".ccr"},      32'(bus.ccr),      32'(e.ccr_after));
                    check({nm, ".flag_any"}, 32'(bus.flag_any), 32'(|e.ccr_after));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Hold one vector for one cycle with the strobe raised.
    task automatic issue(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_vld = 1'b1;
        @(posedge clk);
        #2;
        chk_vld = 1'b0;
    endtask

    // Plain ALU vector: no hazards, so src=B, dst=A, both selects 00.
    task automatic alu(input string nm, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] sh, input logic en,
                       input logic [15:0] er, input logic [2:0] eccr);
        exp_t e;
        bus.rd_data = a;      bus.rs_data = b;
        bus.use_imm = 1'b0;   bus.rd_addr = 3'd1; bus.rs_addr = 3'd2;
        bus.rd_mem = 3'd5;    bus.rd_wb = 3'd6;
        bus.regwrite_mem = 1'b1; bus.regwrite_wb = 1'b1;
        bus.shmnt = sh;       bus.alu_op = op;    bus.alu_en = en;
        e = '{res: er, src: b, dst: a, ssel: 2'b00, dsel: 2'b00,
              ccr_now: 3'b000, ccr_after: eccr, do_comb: 1'b1, do_now: 1'b0, do_after: 1'b1};
        issue(nm, e);
    endtask

    // Forwarding vector: MEM carries AAAA, WB carries 5555, both to r2.
    task automatic fwd(input string nm, input logic [2:0] rs_a, input logic [2:0] rd_a,
                       input logic rwm, input logic rwb, input logic ui, input logic [3:0] op,
                       input logic [15:0] er, input logic [15:0] esrc, input logic [15:0] edst,
                       input logic [1:0] essel, input logic [1:0] edsel, input logic [2:0] eccr);
        exp_t e;
        bus.rd_data = 16'h1111; bus.rs_data = 16'h2222; bus.imm_value = 16'h0042;
        bus.alu_result_mem = 16'hAAAA; bus.wb_data = 16'h5555;
        bus.rd_mem = 3'd2; bus.rd_wb = 3'd2;
        bus.rs_addr = rs_a; bus.rd_addr = rd_a;
        bus.regwrite_mem = rwm; bus.regwrite_wb = rwb; bus.use_imm = ui;
        bus.shmnt = 5'd0; bus.alu_op = op; bus.alu_en = 1'b0;
        e = '{res: er, src: esrc, dst: edst, ssel: essel, dsel: edsel,
              ccr_now: 3'b000, ccr_after: eccr, do_comb: 1'b1, do_now: 1'b0, do_after: 1'b1};
        issue(nm, e);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence. CCR expectations are {C,N,Z}.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        n_total = 0;
        n_pass  = 0;
        chk_vld = 1'b0;
        reset   = 1'b1;
        bus.rs_data = '0; bus.rd_data = '0; bus.imm_value = '0; bus.use_imm = 1'b0;
        bus.shmnt = '0; bus.in_port = '0; bus.alu_op = 4'd0; bus.alu_en = 1'b0;
        bus.rs_addr = 3'd2; bus.rd_addr = 3'd1; bus.rd_mem = 3'd5; bus.rd_wb = 3'd6;
        bus.regwrite_mem = 1'b0; bus.regwrite_wb = 1'b0;
        bus.alu_result_mem = 16'hAAAA; bus.wb_data = 16'h5555;
        #1 reset = 1'b0;

        // Power-on reset, held across an edge with an ALU op that would set flags.
        @(posedge clk); #2;
        bus.rd_data = 16'hFFFF; bus.rs_data = 16'h0001; bus.alu_op = 4'd7; bus.alu_en = 1'b1;
        e = '{res: 16'h0, src: 16'h0, dst: 16'h0, ssel: 2'b00, dsel: 2'b00,
              ccr_now: 3'b000, ccr_after: 3'b000, do_comb: 1'b0, do_now: 1'b1, do_after: 1'b1};
        issue("reset_hold", e);
        reset = 1'b1;

        alu("add_wrap",   4'd7,  16'hFFFF, 16'h0001, 5'd0,  1'b1, 16'h0000, 3'b101);
        alu("sub_borrow", 4'd8,  16'h0003, 16'h0005, 5'd0,  1'b1, 16'hFFFE, 3'b110);
        alu("sub_bubble", 4'd8,  16'h0003, 16'h0005, 5'd0,  1'b0, 16'hFFFE, 3'b110);
        alu("add_bubble", 4'd7,  16'hFFFF, 16'h0001, 5'd0,  1'b0, 16'h0000, 3'b110);
        alu("clrc",       4'd2,  16'h1234, 16'h0000, 5'd0,  1'b1, 16'h1234, 3'b010);
        alu("setc",       4'd1,  16'h0000, 16'h0000, 5'd0,  1'b1, 16'h0000, 3'b110);
        alu("mov",        4'd6,  16'h0007, 16'h0000, 5'd0,  1'b1, 16'h0000, 3'b110);
        alu("inc_wrap",   4'd4,  16'hFFFF, 16'h0000, 5'd0,  1'b1, 16'h0000, 3'b101);
        alu("dec_zero",   4'd5,  16'h0000, 16'h0000, 5'd0,  1'b1, 16'hFFFF, 3'b110);
        alu("dec_8000",   4'd5,  16'h8000, 16'h0000, 5'd0,  1'b1, 16'h7FFF, 3'b000);
        alu("not",        4'd3,  16'h00FF, 16'h0000, 5'd0,  1'b1, 16'hFF00, 3'b010);
        alu("and",        4'd9,  16'hF0F0, 16'h0F0F, 5'd0,  1'b1, 16'h0000, 3'b001);
        alu("or",         4'd10, 16'h8000, 16'h0001, 5'd0,  1'b1, 16'h8001, 3'b010);
        alu("setc2",      4'd1,  16'h0000, 16'h0000, 5'd0,  1'b1, 16'h0000, 3'b110);
        alu("shl_1",      4'd11, 16'h8001, 16'h0000, 5'd1,  1'b1, 16'h0002, 3'b100);
        alu("shr_1",      4'd12, 16'h8001, 16'h0000, 5'd1,  1'b1, 16'h4000, 3'b100);
        alu("clrc2",      4'd2,  16'h0000, 16'h0000, 5'd0,  1'b1, 16'h0000, 3'b000);
        alu("shl_0",      4'd11, 16'h8001, 16'h0000, 5'd0,  1'b1, 16'h8001, 3'b010);
        alu("setc3",      4'd1,  16'h0000, 16'h0000, 5'd0,  1'b1, 16'h0000, 3'b110);
        alu("shr_0",      4'd12, 16'h8001, 16'h0000, 5'd0,  1'b1, 16'h8001, 3'b110);
        alu("shl_20",     4'd11, 16'hFFFF, 16'h0000, 5'd20, 1'b1, 16'h0000, 3'b001);
        alu("shl_16",     4'd11, 16'h0001, 16'h0000, 5'd16, 1'b1, 16'h0000, 3'b101);
        alu("sub_equal",  4'd8,  16'h0005, 16'h0005, 5'd0,  1'b1, 16'h0000, 3'b001);
        alu("add_ovf",    4'd7,  16'h7FFF, 16'h0001, 5'd0,  1'b1, 16'h8000, 3'b010);
        alu("shr_16",     4'd12, 16'h8000, 16'h0000, 5'd16, 1'b1, 16'h0000, 3'b101);
        bus.in_port = 16'h8000;
        alu("in_port",    4'd13, 16'h0001, 16'h0000, 5'd0,  1'b1, 16'h8000, 3'b101);
        alu("reserved14", 4'd14, 16'h1234, 16'h0000, 5'd0,  1'b1, 16'h1234, 3'b101);

        //   name           rs    rd    rwm   rwb   imm   op     res       src       dst       ss     ds     ccr
        fwd("fwd_dst_mem",  3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 4'd0, 16'hAAAA, 16'h2222, 16'hAAAA, 2'b00, 2'b01, 3'b101);
        fwd("fwd_dst_wb",   3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 16'h5555, 16'h2222, 16'h5555, 2'b00, 2'b10, 3'b101);
        fwd("fwd_src_mem",  3'd2, 3'd4, 1'b1, 1'b1, 1'b0, 4'd6, 16'hAAAA, 16'hAAAA, 16'h1111, 2'b01, 2'b00, 3'b101);
        fwd("fwd_src_imm",  3'd2, 3'd4, 1'b1, 1'b1, 1'b1, 4'd6, 16'h0042, 16'h0042, 16'h1111, 2'b00, 2'b00, 3'b101);
        fwd("fwd_src_wb",   3'd2, 3'd4, 1'b0, 1'b1, 1'b0, 4'd6, 16'h5555, 16'h5555, 16'h1111, 2'b10, 2'b00, 3'b101);

        // Mid-cycle reset: CCR must clear before any clock edge.
        bus.alu_en = 1'b0;
        reset = 1'b0;
        e = '{res: 16'h0, src: 16'h0, dst: 16'h0, ssel: 2'b00, dsel: 2'b00,
              ccr_now: 3'b000, ccr_after: 3'b000, do_comb: 1'b0, do_now: 1'b1, do_after: 1'b0};
        exp_q.push_back(e);
        name_q.push_back("reset_async");
        chk_vld = 1'b1;
        @(negedge clk);
        #1;
        reset   = 1'b1;
        chk_vld = 1'b0;

        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
